credit_link_interface: RTL and testbench

//  Credit-flow-controlled master<->slave link: request path (master->slave) and response path
//  (slave->master), each a TX FIFO -> pipelined link -> RX FIFO.
//  Per-direction credit counters guarantee the RX FIFO never overflows.

---
 rtl/credit_link_interface.sv | 164 ++++++++++++++++
 tb/tb_credit_link_interface.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_link_interface.sv
// Credit-flow-controlled master<->slave link: per direction TX FIFO -> link pipe -> RX FIFO, with credit return.
// Optional define CREDIT_LINK_STALL_CNT_EN adds per-direction credit-stall counters.
module credit_link_interface #(
  parameter int DATA_WIDTH      = 40,
  parameter int FIFO_DEPTH      = 32,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int LINK_LATENCY    = 2,
  parameter int CREDIT_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      i_mc_sreq_inbits,
  input  logic                       i_mc_sreq_wen,
  output logic                       o_mc_sreq_fifo_empty,
  output logic                       o_mc_sreq_fifo_full,
  input  logic                       i_sc_rreq_ren,
  output logic                       o_sc_rreq_valid,
  output logic [DATA_WIDTH-1:0]      o_sc_rreq_outbits,
  input  logic [DATA_WIDTH-1:0]      i_sc_sresp_inbits,
  input  logic                       i_sc_sresp_wen,
  output logic                       o_sc_sresp_fifo_empty,
  output logic                       o_sc_sresp_fifo_full,
  input  logic                       i_mc_rresp_ren,
  output logic                       o_mc_rresp_valid,
  output logic [DATA_WIDTH-1:0]      o_mc_rresp_outbits,
  output logic [LOG2_FIFO_DEPTH:0]   o_credits_m2s,
  output logic [LOG2_FIFO_DEPTH:0]   o_credits_s2m
`ifdef CREDIT_LINK_STALL_CNT_EN
  ,
  output logic [15:0]                o_stall_cnt_m2s,
  output logic [15:0]                o_stall_cnt_s2m
`endif
);

  localparam int AW = LOG2_FIFO_DEPTH;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  // Index 0 is the request path (master->slave), index 1 the response path.
  logic [DATA_WIDTH-1:0] in_bits  [2];
  logic                  wen      [2];
  logic                  ren      [2];
  logic                  tx_empty [2];
  logic                  tx_full  [2];
  logic                  rx_valid [2];
  logic [DATA_WIDTH-1:0] rx_bits  [2];
  logic [AW:0]           credits  [2];

  assign in_bits[0] = i_mc_sreq_inbits;
  assign in_bits[1] = i_sc_sresp_inbits;
  assign wen[0]     = i_mc_sreq_wen;
  assign wen[1]     = i_sc_sresp_wen;
  assign ren[0]     = i_sc_rreq_ren;
  assign ren[1]     = i_mc_rresp_ren;

  assign o_mc_sreq_fifo_empty  = tx_empty[0];
  assign o_mc_sreq_fifo_full   = tx_full[0];
  assign o_sc_rreq_valid       = rx_valid[0];
  assign o_sc_rreq_outbits     = rx_bits[0];
  assign o_credits_m2s         = credits[0];
  assign o_sc_sresp_fifo_empty = tx_empty[1];
  assign o_sc_sresp_fifo_full  = tx_full[1];
  assign o_mc_rresp_valid      = rx_valid[1];
  assign o_mc_rresp_outbits    = rx_bits[1];
  assign o_credits_s2m         = credits[1];

`ifdef CREDIT_LINK_STALL_CNT_EN
  logic [15:0] stall_cnt [2];
  assign o_stall_cnt_m2s = stall_cnt[0];
  assign o_stall_cnt_s2m = stall_cnt[1];
`endif

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic [DATA_WIDTH-1:0]     tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     rx_mem [FIFO_DEPTH];
    logic [AW-1:0]             tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0]               tx_count, rx_count, cred;
    logic [LINK_LATENCY-1:0]   link_valid;
    logic [DATA_WIDTH-1:0]     link_data [LINK_LATENCY];
    logic [CREDIT_LATENCY-1:0] cred_pipe;
    logic                      tx_push, launch, rx_push, rx_pop, cred_ret;

    assign tx_push  = wen[d] && (tx_count != DEPTH_CNT);
    assign launch   = (tx_count != '0) && (cred != '0);
    assign rx_push  = link_valid[LINK_LATENCY-1];
    assign rx_pop   = ren[d] && (rx_count != '0);
    assign cred_ret = cred_pipe[CREDIT_LATENCY-1];

    assign tx_empty[d] = (tx_count == '0);
    assign tx_full[d]  = (tx_count == DEPTH_CNT);
    assign rx_valid[d] = (rx_count != '0);
    // Head is masked so stale storage never shows after reset or drain.
    assign rx_bits[d]  = (rx_count != '0) ? rx_mem[rx_rptr] : '0;
    assign credits[d]  = cred;

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr] <= in_bits[d];
      if (rx_push) rx_mem[rx_wptr] <= link_data[LINK_LATENCY-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        tx_wptr    <= '0;
        tx_rptr    <= '0;
        tx_count   <= '0;
        rx_wptr    <= '0;
        rx_rptr    <= '0;
        rx_count   <= '0;
        link_valid <= '0;
        cred_pipe  <= '0;
        cred       <= DEPTH_CNT;
        for (int i = 0; i < LINK_LATENCY; i++) link_data[i] <= '0;
      end else begin
        if (tx_push) tx_wptr <= tx_wptr + 1'b1;
        if (launch)  tx_rptr <= tx_rptr + 1'b1;
        case ({tx_push, launch})
          2'b10:   tx_count <= tx_count + 1'b1;
          2'b01:   tx_count <= tx_count - 1'b1;
          default: tx_count <= tx_count;
        endcase

        link_valid[0] <= launch;
        link_data[0]  <= tx_mem[tx_rptr];
        for (int i = 1; i < LINK_LATENCY; i++) begin
          link_valid[i] <= link_valid[i-1];
          link_data[i]  <= link_data[i-1];
        end

        if (rx_push) rx_wptr <= rx_wptr + 1'b1;
        if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        case ({rx_push, rx_pop})
          2'b10:   rx_count <= rx_count + 1'b1;
          2'b01:   rx_count <= rx_count - 1'b1;
          default: rx_count <= rx_count;
        endcase

        cred_pipe[0] <= rx_pop;
        for (int i = 1; i < CREDIT_LATENCY; i++) cred_pipe[i] <= cred_pipe[i-1];

        // A launch and a returning credit on the same edge cancel out.
        case ({launch, cred_ret})
          2'b10:   cred <= cred - 1'b1;
          2'b01:   cred <= cred + 1'b1;
          default: cred <= cred;
        endcase

        assert (cred <= DEPTH_CNT);
        assert (!(rx_push && (rx_count == DEPTH_CNT)));
      end
    end

`ifdef CREDIT_LINK_STALL_CNT_EN
    logic [15:0] stall;
    assign stall_cnt[d] = stall;

    always_ff @(posedge clk) begin
      if (rst)
        stall <= '0;
      else if ((tx_count != '0) && (cred == '0) && (stall != 16'hFFFF))
        stall <= stall + 16'd1;
    end
`endif
  end

endmodule

// File: tb/tb_credit_link_interface.sv
// Directed self-checking bench for credit_link_interface (default parameters).
module tb_credit_link_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] i_mc_sreq_inbits;
  logic        i_mc_sreq_wen;
  logic        o_mc_sreq_fifo_empty;
  logic        o_mc_sreq_fifo_full;
  logic        i_sc_rreq_ren;
  logic        o_sc_rreq_valid;
  logic [39:0] o_sc_rreq_outbits;
  logic [39:0] i_sc_sresp_inbits;
  logic        i_sc_sresp_wen;
  logic        o_sc_sresp_fifo_empty;
  logic        o_sc_sresp_fifo_full;
  logic        i_mc_rresp_ren;
  logic        o_mc_rresp_valid;
  logic [39:0] o_mc_rresp_outbits;
  logic [5:0]  o_credits_m2s;
  logic [5:0]  o_credits_s2m;
`ifdef CREDIT_LINK_STALL_CNT_EN
  logic [15:0] o_stall_cnt_m2s;
  logic [15:0] o_stall_cnt_s2m;
`endif

  int vectors = 0;
  int miscompares = 0;

  credit_link_interface dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_mc_sreq_inbits      (i_mc_sreq_inbits),
    .i_mc_sreq_wen         (i_mc_sreq_wen),
    .o_mc_sreq_fifo_empty  (o_mc_sreq_fifo_empty),
    .o_mc_sreq_fifo_full   (o_mc_sreq_fifo_full),
    .i_sc_rreq_ren         (i_sc_rreq_ren),
    .o_sc_rreq_valid       (o_sc_rreq_valid),
    .o_sc_rreq_outbits     (o_sc_rreq_outbits),
    .i_sc_sresp_inbits     (i_sc_sresp_inbits),
    .i_sc_sresp_wen        (i_sc_sresp_wen),
    .o_sc_sresp_fifo_empty (o_sc_sresp_fifo_empty),
    .o_sc_sresp_fifo_full  (o_sc_sresp_fifo_full),
    .i_mc_rresp_ren        (i_mc_rresp_ren),
    .o_mc_rresp_valid      (o_mc_rresp_valid),
    .o_mc_rresp_outbits    (o_mc_rresp_outbits),
    .o_credits_m2s         (o_credits_m2s),
    .o_credits_s2m         (o_credits_s2m)
`ifdef CREDIT_LINK_STALL_CNT_EN
    ,
    .o_stall_cnt_m2s       (o_stall_cnt_m2s),
    .o_stall_cnt_s2m       (o_stall_cnt_s2m)
`endif
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving the bench 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_mc_sreq_inbits  = '0;
    i_mc_sreq_wen     = 1'b0;
    i_sc_rreq_ren     = 1'b0;
    i_sc_sresp_inbits = '0;
    i_sc_sresp_wen    = 1'b0;
    i_mc_rresp_ren    = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " sreq_empty"}, 40'(o_mc_sreq_fifo_empty), 40'd1);
    chk({tag, " sreq_full"},  40'(o_mc_sreq_fifo_full),  40'd0);
    chk({tag, " rreq_valid"}, 40'(o_sc_rreq_valid),      40'd0);
    chk({tag, " rreq_bits"},  o_sc_rreq_outbits,         40'd0);
    chk({tag, " sresp_empty"},40'(o_sc_sresp_fifo_empty),40'd1);
    chk({tag, " sresp_full"}, 40'(o_sc_sresp_fifo_full), 40'd0);
    chk({tag, " rresp_valid"},40'(o_mc_rresp_valid),     40'd0);
    chk({tag, " rresp_bits"}, o_mc_rresp_outbits,        40'd0);
    chk({tag, " cred_m2s"},   40'(o_credits_m2s),        40'd32);
    chk({tag, " cred_s2m"},   40'(o_credits_s2m),        40'd32);
`ifdef CREDIT_LINK_STALL_CNT_EN
    chk({tag, " stall_m2s"},  40'(o_stall_cnt_m2s),      40'd0);
    chk({tag, " stall_s2m"},  40'(o_stall_cnt_s2m),      40'd0);
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(2);
    check_idle("reset");
    rst = 1'b0;
    tick(1);
    check_idle("post_reset");
  endtask

  task automatic test_single_word();
    i_mc_sreq_inbits = 40'h12_3456_789A;
    i_mc_sreq_wen    = 1'b1;
    tick(1);
    i_mc_sreq_wen    = 1'b0;
    chk("e0 sreq_empty", 40'(o_mc_sreq_fifo_empty), 40'd0);
    chk("e0 cred_m2s",   40'(o_credits_m2s),        40'd32);
    tick(1);
    chk("e1 cred_m2s",   40'(o_credits_m2s),        40'd31);
    chk("e1 sreq_empty", 40'(o_mc_sreq_fifo_empty), 40'd1);
    tick(1);
    chk("e2 rreq_valid", 40'(o_sc_rreq_valid),      40'd0);
    tick(1);
    chk("e3 rreq_valid", 40'(o_sc_rreq_valid),      40'd1);
    chk("e3 rreq_bits",  o_sc_rreq_outbits,         40'h12_3456_789A);
    chk("e3 cred_s2m",   40'(o_credits_s2m),        40'd32);
    i_sc_rreq_ren = 1'b1;
    tick(1);
    i_sc_rreq_ren = 1'b0;
    chk("pop rreq_valid", 40'(o_sc_rreq_valid),     40'd0);
    chk("pop cred_m2s",   40'(o_credits_m2s),       40'd31);
    tick(1);
    chk("ret cred_m2s",   40'(o_credits_m2s),       40'd32);

    // Response path in isolation.
    i_sc_sresp_inbits = 40'hA5_5A5A_0F0F;
    i_sc_sresp_wen    = 1'b1;
    tick(1);
    i_sc_sresp_wen    = 1'b0;
    tick(1);
    chk("resp e1 cred_s2m", 40'(o_credits_s2m),     40'd31);
    tick(2);
    chk("resp e3 valid",    40'(o_mc_rresp_valid),  40'd1);
    chk("resp e3 bits",     o_mc_rresp_outbits,     40'hA5_5A5A_0F0F);
    chk("resp req idle",    40'(o_sc_rreq_valid),   40'd0);
    i_mc_rresp_ren = 1'b1;
    tick(1);
    i_mc_rresp_ren = 1'b0;
    tick(1);
    chk("resp ret cred_s2m", 40'(o_credits_s2m),    40'd32);
    chk("resp drained",      40'(o_mc_rresp_valid), 40'd0);
  endtask

  // Words 0..39 go out, RX saturates at 32, then one pop lets exactly one more through;
  // afterwards TX is topped up to 32, an overflow write is dropped and everything is drained.
  task automatic test_backpressure();
    int got;
    logic [39:0] exp;
`ifdef CREDIT_LINK_STALL_CNT_EN
    logic [15:0] s0;
`endif
    for (int i = 0; i < 40; i++) begin
      i_mc_sreq_inbits = 40'h100 + 40'(i);
      i_mc_sreq_wen    = 1'b1;
      tick(1);
    end
    i_mc_sreq_wen = 1'b0;
    tick(10);
    chk("bp cred_m2s",   40'(o_credits_m2s),        40'd0);
    chk("bp sreq_empty", 40'(o_mc_sreq_fifo_empty), 40'd0);
    chk("bp sreq_full",  40'(o_mc_sreq_fifo_full),  40'd0);
    chk("bp rreq_valid", 40'(o_sc_rreq_valid),      40'd1);
    chk("bp rreq_head",  o_sc_rreq_outbits,         40'h100);
`ifdef CREDIT_LINK_STALL_CNT_EN
    s0 = o_stall_cnt_m2s;
    tick(3);
    chk("bp stall climb", 40'(o_stall_cnt_m2s), 40'(s0 + 16'd3));
`endif
    i_sc_rreq_ren = 1'b1;
    tick(1);
    i_sc_rreq_ren = 1'b0;
    tick(8);
    chk("bp1 cred_m2s",  40'(o_credits_m2s),        40'd0);
    chk("bp1 rreq_head", o_sc_rreq_outbits,         40'h101);

    // TX holds words 0x121..0x127; add 0x128..0x140 to reach 32.
    for (int i = 40; i < 65; i++) begin
      i_mc_sreq_inbits = 40'h100 + 40'(i);
      i_mc_sreq_wen    = 1'b1;
      tick(1);
    end
    chk("bp tx full",    40'(o_mc_sreq_fifo_full),  40'd1);
    i_mc_sreq_inbits = 40'hDE_ADDE_ADDE;
    tick(1);
    i_mc_sreq_wen = 1'b0;
    chk("bp overflow full", 40'(o_mc_sreq_fifo_full), 40'd1);

    got = 0;
    exp = 40'h101;
    i_sc_rreq_ren = 1'b1;
    for (int c = 0; c < 400 && got < 64; c++) begin
      if (o_sc_rreq_valid) begin
        chk("drain order", o_sc_rreq_outbits, exp);
        exp++;
        got++;
      end
      tick(1);
    end
    tick(10);
    i_sc_rreq_ren = 1'b0;
    chk("drain count",      40'(got),                  40'd64);
    chk("drain no extra",   40'(o_sc_rreq_valid),      40'd0);
    chk("drain tx empty",   40'(o_mc_sreq_fifo_empty), 40'd1);
    chk("drain cred_m2s",   40'(o_credits_m2s),        40'd32);
  endtask

  task automatic test_back_to_back();
    logic [39:0] q_req[$];
    logic [39:0] q_rsp[$];
    logic [63:0] r;
    i_sc_rreq_ren  = 1'b1;
    i_mc_rresp_ren = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom(), $urandom()};
      i_mc_sreq_inbits = r[39:0];
      r = {$urandom(), $urandom()};
      i_sc_sresp_inbits = r[63:24];
      i_mc_sreq_wen  = 1'b1;
      i_sc_sresp_wen = 1'b1;
      if (!o_mc_sreq_fifo_full)  q_req.push_back(i_mc_sreq_inbits);
      if (!o_sc_sresp_fifo_full) q_rsp.push_back(i_sc_sresp_inbits);
      if (o_sc_rreq_valid) begin
        if (q_req.size() == 0) chk("b2b req spurious", 40'd1, 40'd0);
        else chk("b2b req data", o_sc_rreq_outbits, q_req.pop_front());
      end
      if (o_mc_rresp_valid) begin
        if (q_rsp.size() == 0) chk("b2b rsp spurious", 40'd1, 40'd0);
        else chk("b2b rsp data", o_mc_rresp_outbits, q_rsp.pop_front());
      end
      // In steady state four credits per path are always in transit.
      if (i >= 8) begin
        chk("b2b req rate", 40'(o_sc_rreq_valid),  40'd1);
        chk("b2b rsp rate", 40'(o_mc_rresp_valid), 40'd1);
        chk("b2b cred_m2s", 40'(o_credits_m2s),    40'd28);
        chk("b2b cred_s2m", 40'(o_credits_s2m),    40'd28);
      end
      tick(1);
    end
    i_mc_sreq_wen  = 1'b0;
    i_sc_sresp_wen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (o_sc_rreq_valid) begin
        if (q_req.size() == 0) chk("tail req spurious", 40'd1, 40'd0);
        else chk("tail req data", o_sc_rreq_outbits, q_req.pop_front());
      end
      if (o_mc_rresp_valid) begin
        if (q_rsp.size() == 0) chk("tail rsp spurious", 40'd1, 40'd0);
        else chk("tail rsp data", o_mc_rresp_outbits, q_rsp.pop_front());
      end
      tick(1);
    end
    i_sc_rreq_ren  = 1'b0;
    i_mc_rresp_ren = 1'b0;
    chk("b2b req left", 40'(q_req.size()), 40'd0);
    chk("b2b rsp left", 40'(q_rsp.size()), 40'd0);
    check_idle("b2b end");
  endtask

  task automatic test_reset_mid_traffic();
    for (int i = 0; i < 10; i++) begin
      i_mc_sreq_inbits  = 40'h5500 + 40'(i);
      i_sc_sresp_inbits = 40'h6600 + 40'(i);
      i_mc_sreq_wen     = 1'b1;
      i_sc_sresp_wen    = 1'b1;
      tick(1);
    end
    idle_inputs();
    rst = 1'b1;
    tick(1);
    check_idle("midrst");
    rst = 1'b0;
    i_sc_rreq_ren  = 1'b1;
    i_mc_rresp_ren = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      chk("midrst req stale", 40'(o_sc_rreq_valid),  40'd0);
      chk("midrst rsp stale", 40'(o_mc_rresp_valid), 40'd0);
    end
    idle_inputs();
    check_idle("midrst end");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
